// File: rtl/apb_ctrl_pkg.sv
// Shared APB controller types: FSM state encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Wait counter width; holds any TIMEOUT up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/globals_pkg.sv
// Project-wide constants shared by all blocks in this slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package globals_pkg;

  // Width of any requester index; covers up to 8 requesters.
  localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/apb_rr_arb.sv
// Round-robin one-hot selector: first active request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req  - request vector
//        ptr  - index holding highest priority (one past the last grant)
//        gnt  - one-hot grant, all zero when no request is active
module apb_rr_arb
  import globals_pkg::*;
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

  // Walk candidates in priority order ptr, ptr+1, ... and take the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/apb_rr_requester.sv
// Shares one APB requester port among NUM_REQ clients with round-robin arbitration.
// Latency: accept, SETUP, ACCESS (+1 per pready=0 cycle, abort after TIMEOUT), RESP pulse.
// Backpressure: req_ready is a one-cycle pulse in IDLE only; one transfer in flight at a time.
// Ports: pclk/prst                      - clock, synchronous active-low reset
//        req_valid/req_ready/req_write  - per-client handshake and direction
//        req_addr/req_wdata             - per-client payload, client i in slice i
//        rsp_valid/rsp_rdata/rsp_err    - completion pulse to the owner, read data, timeout flag
//        paddr/pselx/penable/pwrite/pwdata, pready/prdata - APB bus
module apb_rr_requester
  import globals_pkg::*;
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pselx,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata
);

  apb_state_e          state;
  apb_state_e          state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    owner;
  logic [NUM_REQ-1:0]  gnt;
  logic [CNT_W-1:0]    wait_cnt;
  logic                accept;
  logic                done_ok;
  logic                done_to;
  logic [IDX_W-1:0]    acc_idx;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;

  apb_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // req_ready is registered, so the grant is decided one cycle ahead from the
  // valids seen then; the handshake only completes if that client still holds valid.
  assign accept  = (state == IDLE) && ((req_ready & req_valid) != '0);
  assign done_ok = (state == ACCESS) && pready;
  assign done_to = (state == ACCESS) && !pready && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Payload of the client whose ready bit is up (at most one bit is set).
  always_comb begin
    acc_idx   = '0;
    acc_write = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        acc_idx   = IDX_W'(i);
        acc_write = req_write[i];
        acc_addr  = req_addr[i*ADDR_W +: ADDR_W];
        acc_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!prst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done_ok || done_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      paddr     <= '0;
      pselx     <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      wait_cnt  <= '0;
    end else begin
      pselx     <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable   <= (state_nxt == ACCESS);
      req_ready <= (state_nxt == IDLE) ? gnt : '0;

      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] <= (done_ok || done_to) && (owner == IDX_W'(i));
      end

      if (done_ok) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (done_to) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end

      // Bus payload is loaded only on accept and otherwise holds its last value.
      if (accept) begin
        paddr  <= acc_addr;
        pwrite <= acc_write;
        pwdata <= acc_wdata;
        owner  <= acc_idx;
        rr_ptr <= (acc_idx == IDX_W'(NUM_REQ - 1)) ? '0 : acc_idx + 1'b1;
      end

      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_requester.sv
// Directed self-checking bench for apb_rr_requester (NUM_REQ=2, ADDR_W=5, DATA_W=32, TIMEOUT=16).
// Inputs change and outputs are sampled 1 time unit after each rising pclk edge.
// Latency is counted inclusively: the accept cycle is cycle 1, the rsp_valid cycle is cycle N.
module tb_apb_rr_requester;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 16;

  logic             pclk;
  logic             prst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [AW-1:0]    paddr;
  logic             pselx;
  logic             penable;
  logic             pwrite;
  logic [DW-1:0]    pwdata;
  logic             pready;
  logic [DW-1:0]    prdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [NR-1:0] g;
  logic [NR-1:0] grants [4];
  int            acc_at [4];
  int            lat;
  int            pen;
  bit            addr_ok;
  logic [NR-1:0] rsp_seen;

  apb_rr_requester #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .pclk      (pclk),
    .prst      (prst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until a handshake (req_valid & req_ready) is seen; gg = ready bits then, 0 if none.
  task automatic wait_accept(output logic [NR-1:0] gg);
    bit got;
    got = 1'b0;
    gg  = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if ((req_ready & req_valid) != '0) begin
        gg  = req_ready;
        got = 1'b1;
      end
    end
  endtask

  // Step until rsp_valid; counts latency from lat0, ACCESS cycles, and paddr stability.
  // When rdy_at > 0, pready is raised during the rdy_at-th ACCESS cycle.
  task automatic wait_rsp(input int limit, input int lat0, input int rdy_at,
                          input logic [AW-1:0] exp_addr,
                          output int lt, output int pn, output bit aok);
    bit got;
    got = 1'b0;
    lt  = lat0;
    pn  = 0;
    aok = 1'b1;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      lt++;
      if (penable) begin
        pn++;
        if (paddr !== exp_addr) aok = 1'b0;
        if (rdy_at > 0 && pn == rdy_at) pready = 1'b1;
      end
      if (rsp_valid != '0) got = 1'b1;
    end
  endtask

  initial begin
    prst      = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b1;
    prdata    = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_ctl", 128'({pselx, penable, pwrite, req_ready, rsp_valid, rsp_err}), 128'd0);
    chk("rst_dat", 128'({paddr, pwdata, rsp_rdata}), 128'd0);
    prst = 1'b1;
    tick();

    // Single write from requester 0, pready tied high
    req_valid      = 2'b01;
    req_write      = 2'b01;
    req_addr[4:0]  = 5'h0A;
    req_wdata[31:0] = 32'hDEADBEEF;
    wait_accept(g);
    chk("t1_grant", 128'(g), 128'(2'b01));
    chk("t1_bus_idle_at_accept", 128'({pselx, penable}), 128'd0);
    tick();
    chk("t1_setup_ctl", 128'({pselx, penable, pwrite}), 128'(3'b101));
    chk("t1_setup_addr", 128'(paddr), 128'(5'h0A));
    chk("t1_setup_wdata", 128'(pwdata), 128'(32'hDEADBEEF));
    chk("t1_ready_low_in_setup", 128'(req_ready), 128'd0);
    req_valid = '0;
    wait_rsp(20, 2, 0, 5'h0A, lat, pen, addr_ok);
    chk("t1_latency", 128'(lat), 128'd4);
    chk("t1_access_cycles", 128'(pen), 128'd1);
    chk("t1_rsp_valid", 128'(rsp_valid), 128'(2'b01));
    chk("t1_rsp_err_rdata", 128'({rsp_err, rsp_rdata}), 128'd0);
    chk("t1_resp_bus", 128'({pselx, penable}), 128'd0);
    tick();
    chk("t1_idle_pulse_gone", 128'(rsp_valid), 128'd0);
    chk("t1_idle_hold", 128'({pselx, penable, pwrite, paddr, pwdata}), 128'({3'b001, 5'h0A, 32'hDEADBEEF}));

    // Read from requester 1 with three wait states; address changed and valid dropped during SETUP
    req_valid     = 2'b10;
    req_write     = 2'b00;
    req_addr[9:5] = 5'h03;
    pready        = 1'b0;
    prdata        = 32'h12345678;
    wait_accept(g);
    chk("t2_grant", 128'(g), 128'(2'b10));
    tick();
    chk("t2_setup", 128'({pselx, penable, pwrite, paddr}), 128'({3'b100, 5'h03}));
    req_addr[9:5] = 5'h1F;
    req_valid     = '0;
    wait_rsp(40, 2, 4, 5'h03, lat, pen, addr_ok);
    chk("t2_latency", 128'(lat), 128'd7);
    chk("t2_penable_cycles", 128'(pen), 128'd4);
    chk("t2_paddr_stable", 128'(addr_ok), 128'd1);
    chk("t2_rsp_valid", 128'(rsp_valid), 128'(2'b10));
    chk("t2_rdata", 128'(rsp_rdata), 128'(32'h12345678));
    chk("t2_err", 128'(rsp_err), 128'd0);
    tick();

    // Both requesters hold valid: four back-to-back transfers alternate 0,1,0,1
    pready    = 1'b1;
    prdata    = 32'hCAFEF00D;
    req_write = 2'b01;
    req_addr  = {5'h12, 5'h11};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_accept(grants[k]);
      acc_at[k] = cyc;
    end
    chk("t3_grant0", 128'(grants[0]), 128'(2'b01));
    chk("t3_grant1", 128'(grants[1]), 128'(2'b10));
    chk("t3_grant2", 128'(grants[2]), 128'(2'b01));
    chk("t3_grant3", 128'(grants[3]), 128'(2'b10));
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("t3_spacing%0d", k), 128'(acc_at[k] - acc_at[k-1]), 128'd4);
    end
    tick();
    req_valid = '0;
    wait_rsp(20, 2, 0, 5'h12, lat, pen, addr_ok);
    chk("t3_last_rsp", 128'(rsp_valid), 128'(2'b10));
    chk("t3_last_rdata", 128'(rsp_rdata), 128'(32'hCAFEF00D));
    chk("t3_last_latency", 128'(lat), 128'd4);
    tick();

    // Timeout: pready held low
    pready    = 1'b0;
    prdata    = 32'hA5A5A5A5;
    req_write = 2'b00;
    req_valid = 2'b01;
    wait_accept(g);
    chk("t4_grant", 128'(g), 128'(2'b01));
    tick();
    req_valid = '0;
    wait_rsp(40, 2, 0, 5'h11, lat, pen, addr_ok);
    chk("t4_access_cycles", 128'(pen), 128'd16);
    chk("t4_latency", 128'(lat), 128'd19);
    chk("t4_rsp_valid", 128'(rsp_valid), 128'(2'b01));
    chk("t4_err", 128'(rsp_err), 128'd1);
    chk("t4_rdata_zero", 128'(rsp_rdata), 128'd0);
    chk("t4_resp_bus", 128'({pselx, penable}), 128'd0);
    tick();

    // Reset during ACCESS of a requester-0 transfer
    req_write     = 2'b01;
    req_addr[4:0] = 5'h07;
    req_valid     = 2'b01;
    wait_accept(g);
    chk("t5_grant", 128'(g), 128'(2'b01));
    tick();
    req_valid = '0;
    tick();
    chk("t5_in_access", 128'({pselx, penable}), 128'(2'b11));
    prst = 1'b0;
    tick();
    chk("t5_bus_after_rst", 128'({pselx, penable}), 128'd0);
    chk("t5_no_rsp_at_rst", 128'(rsp_valid), 128'd0);
    chk("t5_paddr_rst", 128'(paddr), 128'd0);
    prst     = 1'b1;
    pready   = 1'b1;
    rsp_seen = '0;
    repeat (5) begin
      tick();
      rsp_seen = rsp_seen | rsp_valid;
    end
    chk("t5_no_rsp_after_rst", 128'(rsp_seen), 128'd0);
    req_valid = 2'b11;
    wait_accept(g);
    chk("t5_grant_after_rst", 128'(g), 128'(2'b01));
    tick();
    req_valid = '0;
    wait_rsp(20, 2, 0, 5'h07, lat, pen, addr_ok);
    chk("t5_rsp_after_rst", 128'(rsp_valid), 128'(2'b01));
    chk("t5_latency_after_rst", 128'(lat), 128'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_rr_requester.md
APB_RR_REQUESTER -- requirements
Module: apb_rr_requester

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the APB bus, range 2..8.
REQ-002 Parameter ADDR_W, default 5: APB address width.
REQ-003 Parameter DATA_W, default 32: APB data width.
REQ-004 Parameter TIMEOUT, default 16: maximum ACCESS cycles waiting for pready before abort, range 2..255.
REQ-005 pclk  in  1  single clock; all logic on its rising edge.
REQ-006 prst  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester transfer request.
REQ-008 req_ready  out  NUM_REQ  per-requester accept strobe; request is accepted when valid and ready are both high in one cycle.
REQ-009 req_write  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
REQ-010 req_addr  in  NUM_REQ*ADDR_W  per-requester address, requester i in slice i.
REQ-011 req_wdata  in  NUM_REQ*DATA_W  per-requester write data, requester i in slice i.
REQ-012 rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-013 rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes and errors.
REQ-014 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-015 paddr, pselx, penable, pwrite, pwdata  out  ADDR_W,1,1,1,DATA_W  APB requester signals.
REQ-016 pready, prdata  in  1, DATA_W  APB completer signals.

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-018 In IDLE with any req_valid high, the arbiter SHALL grant one requester, pulse its req_ready for that cycle, latch its write/addr/wdata and index, then go to SETUP.
REQ-019 Arbitration SHALL be round-robin: search starts at the index after the last granted requester and wraps from NUM_REQ-1 to 0; after reset, requester 0 has highest priority.
REQ-020 At most one req_ready bit SHALL be high, and only in IDLE.
REQ-021 In SETUP, pselx=1 and penable=0, with paddr/pwrite/pwdata from the latched request; the next state SHALL be ACCESS unconditionally.
REQ-022 In ACCESS, pselx=1 and penable=1; paddr/pwrite/pwdata SHALL stay stable until the state is left.
REQ-023 In ACCESS with pready=1, the FSM SHALL go to RESP; on a read it SHALL capture prdata, and set rsp_err to 0.
REQ-024 The ACCESS wait counter SHALL clear on entry and increment each cycle pready=0; at count TIMEOUT-1 with pready=0, the FSM SHALL go to RESP with rsp_err=1 and rdata=0.
REQ-025 In RESP, rsp_valid[owner] SHALL be high for exactly one cycle and pselx/penable SHALL be 0; the next state SHALL be IDLE.
REQ-026 Minimum transfer latency SHALL be 4 cycles from accept to rsp_valid; each pready=0 cycle adds 1.
REQ-027 Outside SETUP/ACCESS, pselx and penable SHALL be 0, while paddr/pwdata/pwrite hold their last values.
REQ-028 Back-to-back transfers SHALL leave one idle cycle (IDLE) between RESP and the next SETUP.
REQ-029 req_valid deasserting while the FSM is not in IDLE SHALL have no effect on the transfer in flight.

Reset
REQ-030 On reset (prst=0 at a pclk edge) the FSM SHALL enter IDLE, even mid-transfer; no rsp_valid is issued for an aborted transfer.
REQ-031 Reset values SHALL be: pselx, penable, pwrite, req_ready, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0; round-robin pointer and wait counter = 0.

Structure
REQ-032 The FSM state enum and the default widths and TIMEOUT constants SHALL live in shared package apb_ctrl_pkg, imported alongside globals_pkg.
REQ-033 Round-robin selection SHALL be a combinational sub-module apb_rr_arb (inputs: request vector and last-grant pointer; output: one-hot grant).
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Single write, req 0, addr 5'h0A, data 32'hDEADBEEF, pready tied 1 -> SETUP then ACCESS on the bus, rsp_valid[0] 4 cycles after accept, rsp_err=0.
REQ-036 Read, req 1, addr 5'h03, prdata 32'h12345678, pready low for 3 ACCESS cycles -> penable high 4 cycles, rsp_rdata=32'h12345678, latency 7.
REQ-037 Both requesters hold valid for 4 transfers -> grants in order 0,1,0,1; one IDLE cycle between transfers.
REQ-038 pready held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_valid with rsp_err=1, rsp_rdata=0, pselx=0.
REQ-039 prst=0 asserted during ACCESS -> next cycle pselx=penable=0, no rsp_valid; the next grant goes to requester 0.
REQ-040 Requester 1 changes req_addr and deasserts req_valid during SETUP -> paddr unchanged through ACCESS, transfer completes normally.
